// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter: the capture writer has priority, the readback
// reader is protected from starvation, and one outstanding read is tracked with a timeout.
module sdram_arbiter #(
    parameter int ADDR_W        = 23,
    parameter int DATA_W        = 32,
    parameter int MAX_WR_STREAK = 8,
    parameter int RD_TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    // capture write path
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    // readback read path
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    // SDRAM controller command interface
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    output logic              in_valid,
    input  logic              busy,
    input  logic [DATA_W-1:0] data_out,
    input  logic              out_valid,
    // LED status
    output logic [1:0]        state_code
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    localparam logic [7:0]  STREAK_LIM = 8'(MAX_WR_STREAK);
    localparam logic [15:0] TMO_LAST   = 16'(RD_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wr_streak;
    logic [15:0] tmo_cnt;
    logic        grant_any;
    logic        rd_wins;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A pending read overtakes writes once the writer has had its streak.
    assign grant_any  = !busy && (wr_req || rd_req);
    assign rd_wins    = rd_req && (!wr_req || (wr_streak >= STREAK_LIM));
    assign state_code = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_streak <= 8'd0;
            tmo_cnt   <= 16'd0;
            addr      <= '0;
            rw        <= 1'b0;
            data_in   <= '0;
            in_valid  <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
        end else begin
            in_valid <= 1'b0;
            wr_ack   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        in_valid <= 1'b1;
                        if (rd_wins) begin
                            rw        <= 1'b0;
                            addr      <= rd_addr;
                            rd_ack    <= 1'b1;
                            wr_streak <= 8'd0;
                            tmo_cnt   <= 16'd0;
                            state     <= ST_RD_WAIT;
                        end else begin
                            rw        <= 1'b1;
                            addr      <= wr_addr;
                            data_in   <= wr_data;
                            wr_ack    <= 1'b1;
                            wr_streak <= rd_req ? sat_inc8(wr_streak) : 8'd0;
                            state     <= ST_HOLD;
                        end
                    end
                end
                // One dead cycle covers the controller's busy rise latency.
                ST_HOLD: begin
                    state <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    if (out_valid) begin
                        rd_data  <= data_out;
                        rd_valid <= 1'b1;
                        rd_err   <= 1'b0;
                        tmo_cnt  <= 16'd0;
                        state    <= ST_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rd_valid <= 1'b1;
                        rd_err   <= 1'b1;
                        tmo_cnt  <= 16'd0;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: stimulus queues expected commands, read returns
// and state codes tagged with their cycle; a negedge monitor compares every cycle.
module tb_sdram_arbiter;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef struct {
        int              cy;
        logic            rw;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } cmd_t;

    typedef struct {
        int              cy;
        logic [DATA_W-1:0] d;
        logic            err;
    } rdr_t;

    typedef struct {
        int         cy;
        logic [1:0] code;
        logic       zero;
    } st_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] data_in;
    logic              in_valid;
    logic              busy = 1'b0;
    logic [DATA_W-1:0] data_out = '0;
    logic              out_valid = 1'b0;
    logic [1:0]        state_code;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic done = 1'b0;

    cmd_t cmd_q[$];
    rdr_t rd_q[$];
    st_t  st_q[$];

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_WR_STREAK(8),
        .RD_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_ack(rd_ack),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_err(rd_err),
        .addr(addr),
        .rw(rw),
        .data_in(data_in),
        .in_valid(in_valid),
        .busy(busy),
        .data_out(data_out),
        .out_valid(out_valid),
        .state_code(state_code)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: the only process that compares and counts.
    cmd_t mc;
    rdr_t mr;
    st_t  ms;
    logic exp_cmd;
    logic exp_rd;

    always @(negedge clk) begin
        if (done) begin
            chk("cmd_queue_left", 32'(cmd_q.size()), 32'd0);
            chk("rd_queue_left", 32'(rd_q.size()), 32'd0);
            chk("st_queue_left", 32'(st_q.size()), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else begin
            exp_cmd = (cmd_q.size() > 0) && (cmd_q[0].cy == cyc);
            chk("in_valid", 32'(in_valid), 32'(exp_cmd));
            if (exp_cmd) begin
                mc = cmd_q.pop_front();
                chk("rw", 32'(rw), 32'(mc.rw));
                chk("addr", 32'(addr), 32'(mc.a));
                if (mc.rw) chk("data_in", data_in, mc.d);
                chk("wr_ack", 32'(wr_ack), 32'(mc.rw));
                chk("rd_ack", 32'(rd_ack), 32'(!mc.rw));
            end else begin
                chk("wr_ack_idle", 32'(wr_ack), 32'd0);
                chk("rd_ack_idle", 32'(rd_ack), 32'd0);
            end

            exp_rd = (rd_q.size() > 0) && (rd_q[0].cy == cyc);
            chk("rd_valid", 32'(rd_valid), 32'(exp_rd));
            if (exp_rd) begin
                mr = rd_q.pop_front();
                chk("rd_data", rd_data, mr.d);
                chk("rd_err", 32'(rd_err), 32'(mr.err));
            end

            if ((st_q.size() > 0) && (st_q[0].cy == cyc)) begin
                ms = st_q.pop_front();
                chk("state_code", 32'(state_code), 32'(ms.code));
                if (ms.zero) begin
                    chk("rst_addr", 32'(addr), 32'd0);
                    chk("rst_rw", 32'(rw), 32'd0);
                    chk("rst_data_in", data_in, 32'd0);
                    chk("rst_rd_data", rd_data, 32'd0);
                    chk("rst_rd_err", 32'(rd_err), 32'd0);
                    chk("rst_in_valid", 32'(in_valid), 32'd0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic want_cmd(input int cy, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        cmd_t t;
        t.cy = cy; t.rw = w; t.a = a; t.d = d;
        cmd_q.push_back(t);
    endtask

    task automatic want_rd(input int cy, input logic [DATA_W-1:0] d, input logic err);
        rdr_t t;
        t.cy = cy; t.d = d; t.err = err;
        rd_q.push_back(t);
    endtask

    task automatic want_st(input int cy, input logic [1:0] code, input logic zero);
        st_t t;
        t.cy = cy; t.code = code; t.zero = zero;
        st_q.push_back(t);
    endtask

    int c;

    initial begin
        #1 rst_n = 1'b0;
        want_st(cyc + 1, 2'd0, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(1);

        // single write
        c = cyc;
        wr_req = 1'b1; wr_addr = 23'h000010; wr_data = 32'hDEADBEEF;
        want_cmd(c + 1, 1'b1, 23'h000010, 32'hDEADBEEF);
        want_st(c + 1, 2'd1, 1'b0);
        want_st(c + 2, 2'd0, 1'b0);
        step(1);
        wr_req = 1'b0;
        step(3);

        // single read, data returned 5 cycles after the command
        c = cyc;
        rd_req = 1'b1; rd_addr = 23'h000020;
        want_cmd(c + 1, 1'b0, 23'h000020, 32'h0);
        want_st(c + 1, 2'd2, 1'b0);
        want_rd(c + 7, 32'hCAFEF00D, 1'b0);
        want_st(c + 7, 2'd0, 1'b0);
        step(1);
        rd_req = 1'b0;
        step(5);
        out_valid = 1'b1; data_out = 32'hCAFEF00D;
        step(1);
        out_valid = 1'b0;
        step(1);
        // stray out_valid while idle must be ignored
        out_valid = 1'b1; data_out = 32'h12345678;
        step(1);
        out_valid = 1'b0;
        step(3);

        // starvation guard: 8 writes, then the read, then writes resume
        c = cyc;
        wr_req = 1'b1; wr_addr = 23'h000100; wr_data = 32'h11110000;
        rd_req = 1'b1; rd_addr = 23'h000200;
        for (int k = 0; k < 8; k++) want_cmd(c + 1 + 2 * k, 1'b1, 23'h000100, 32'h11110000);
        want_cmd(c + 17, 1'b0, 23'h000200, 32'h0);
        want_st(c + 17, 2'd2, 1'b0);
        want_rd(c + 20, 32'hA5A50001, 1'b0);
        want_st(c + 20, 2'd0, 1'b0);
        want_cmd(c + 21, 1'b1, 23'h000100, 32'h11110000);
        want_cmd(c + 23, 1'b1, 23'h000100, 32'h11110000);
        step(17);
        rd_req = 1'b0;
        step(2);
        out_valid = 1'b1; data_out = 32'hA5A50001;
        step(1);
        out_valid = 1'b0;
        step(3);
        wr_req = 1'b0;
        step(4);

        // read timeout: no out_valid ever
        c = cyc;
        rd_req = 1'b1; rd_addr = 23'h000030;
        want_cmd(c + 1, 1'b0, 23'h000030, 32'h0);
        want_st(c + 255, 2'd2, 1'b0);
        want_rd(c + 256, 32'hA5A50001, 1'b1);
        want_st(c + 256, 2'd0, 1'b0);
        step(1);
        rd_req = 1'b0;
        step(262);

        // busy stall for 20 cycles
        c = cyc;
        busy = 1'b1;
        wr_req = 1'b1; wr_addr = 23'h000040; wr_data = 32'h0BADF00D;
        want_st(c + 10, 2'd0, 1'b0);
        want_cmd(c + 21, 1'b1, 23'h000040, 32'h0BADF00D);
        step(20);
        busy = 1'b0;
        step(1);
        wr_req = 1'b0;
        step(3);

        // reset while a read is outstanding
        c = cyc;
        rd_req = 1'b1; rd_addr = 23'h000055;
        want_cmd(c + 1, 1'b0, 23'h000055, 32'h0);
        want_st(c + 1, 2'd2, 1'b0);
        step(1);
        rd_req = 1'b0;
        step(2);
        rst_n = 1'b0;
        want_st(c + 3, 2'd0, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(1);
        out_valid = 1'b1; data_out = 32'hFFFF0000;
        want_st(c + 8, 2'd0, 1'b0);
        step(1);
        out_valid = 1'b0;
        step(2);

        // normal write after reset at the top of the address range
        c = cyc;
        wr_req = 1'b1; wr_addr = 23'h7FFFFF; wr_data = 32'h80000001;
        want_cmd(c + 1, 1'b1, 23'h7FFFFF, 32'h80000001);
        step(1);
        wr_req = 1'b0;
        step(4);
        done = 1'b1;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter placed between the SDRAM controller's command interface and its two users: the capture write path (the sample_checker pixel stream) and the readback read path that drains frames to the AVR. It grants one single-word command at a time, gives the capture writer priority, guarantees the reader forward progress, tracks the one outstanding read and returns its data. It exposes a 2-bit state code for the LED bank.

## Interface
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, SDRAM word width
- MAX_WR_STREAK, 8, consecutive write grants allowed while a read is pending (range 1..255)
- RD_TIMEOUT, 255, cycles to wait for out_valid before aborting a read (range 1..65535)

Ports:
- clk  in  1  system clock; every register is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  capture write request; level, held until wr_ack
- wr_addr  in  ADDR_W  write address; stable while wr_req=1
- wr_data  in  DATA_W  write data; stable while wr_req=1
- wr_ack  out  1  one-cycle pulse: the write was issued to SDRAM
- rd_req  in  1  readback request; level, held until rd_ack
- rd_addr  in  ADDR_W  read address; stable while rd_req=1
- rd_ack  out  1  one-cycle pulse: the read was issued
- rd_valid  out  1  one-cycle pulse: rd_data/rd_err are valid
- rd_data  out  DATA_W  read data (holds last value)
- rd_err  out  1  qualified by rd_valid: 1 means the read timed out and rd_data is stale
- addr  out  ADDR_W  to controller
- rw  out  1  to controller; 1=write, 0=read
- data_in  out  DATA_W  to controller, write data
- in_valid  out  1  to controller, one-cycle command strobe
- busy  in  1  from controller; no command accepted while 1
- data_out  in  DATA_W  from controller, read data
- out_valid  in  1  from controller, read data strobe
- state_code  out  2  0=IDLE, 1=HOLD, 2=RD_WAIT, 3=reserved

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, wr_streak 0, timeout counter 0.
- IDLE: a grant is issued only when busy=0 and at least one request is high.
  - Selection: read wins if rd_req=1 and (wr_req=0 or wr_streak >= MAX_WR_STREAK); otherwise write wins.
  - Write grant, registered at the next edge: in_valid=1, rw=1, addr=wr_addr, data_in=wr_data, wr_ack=1, state becomes HOLD. wr_streak increments (saturating at 255) if rd_req=1, otherwise it clears to 0.
  - Read grant, registered at the next edge: in_valid=1, rw=0, addr=rd_addr, rd_ack=1, wr_streak=0, state becomes RD_WAIT.
- HOLD: lasts one cycle and masks the controller's busy rise latency. in_valid and wr_ack drop to 0. State returns to IDLE.
- RD_WAIT: in_valid and rd_ack drop after one cycle. No new grant is made. The timeout counter increments each cycle.
  - When out_valid=1: rd_data=data_out, rd_valid=1, rd_err=0, state becomes IDLE.
  - When the counter reaches RD_TIMEOUT without out_valid: rd_valid=1, rd_err=1, rd_data unchanged, state becomes IDLE.
  - The counter clears on leaving RD_WAIT.
  - An out_valid seen outside RD_WAIT is ignored.
- addr, rw and data_in hold their last values between commands.
- If a requester drops its request before ack, nothing is issued for it; the arbiter takes no further action.
- Reset asserted mid-operation: everything returns to reset values immediately. An in-flight read is dropped silently and no rd_valid is produced.

## Timing
- Write: req sampled at edge E (IDLE, busy=0), then in_valid+wr_ack at E+1, then IDLE at E+2. Earliest next grant is at E+3, so the best-case issue rate is 1 command per 2 cycles.
- Read: issued at E+1. rd_valid comes 1 cycle after the cycle in which out_valid is sampled.
- A requester must not change addr/data in the cycle its ack is high. It may drop the request in the ack cycle or hold it for another access; a held request is treated as a new request.
- busy=1 in IDLE stalls indefinitely with no timeout.

## Test plan
- Write only: wr_req=1, addr=0x000010, data=0xDEADBEEF, busy=0. Expect in_valid/rw=1/wr_ack at E+1 with those exact values, then HOLD, then IDLE.
- Read: rd_req=1, addr=0x000020, controller returns 0xCAFEF00D with out_valid 5 cycles after in_valid. Expect rd_valid=1 one cycle later, rd_data=0xCAFEF00D, rd_err=0.
- Starvation guard: wr_req and rd_req both held, MAX_WR_STREAK=8. Expect exactly 8 wr_acks, then rd_ack, then writes resume.
- Timeout: issue a read and never assert out_valid, RD_TIMEOUT=255. Expect rd_valid with rd_err=1 255 cycles after the command, then IDLE.
- busy held at 1 for 20 cycles with wr_req=1. Expect no in_valid during the stall, then a grant one cycle after busy falls.
- rst_n pulsed low while in RD_WAIT. Expect all outputs 0 asynchronously, no rd_valid afterwards, and state_code=0.
